// File: rtl/pet_kbd_pkg.sv
// Shared types and PET keyboard geometry for the key injector.
package pet_kbd_pkg;

  // PET graphics-keyboard matrix geometry and SHIFT position.
  localparam int PET_ROWS      = 10;
  localparam int PET_COLS      = 8;
  localparam int PET_SHIFT_ROW = 8;
  localparam int PET_SHIFT_COL = 0;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int PET_RW = idx_width(PET_ROWS);
  localparam int PET_CW = idx_width(PET_COLS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP
  } kbd_state_t;

  // Key event at the stock PET geometry.
  typedef struct packed {
    logic              shift;
    logic [PET_RW-1:0] row;
    logic [PET_CW-1:0] col;
  } pet_event_t;

endpackage

// File: rtl/pet_key_fifo.sv
// Synchronous FIFO with registered full/empty flags and an occupancy count.
module pet_key_fifo
  import pet_kbd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = idx_width(DEPTH),
  localparam int NW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [NW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [NW-1:0]    count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    // NOTE: default first so every path assigns count_next and no latch is inferred.
    count_next = count;
    unique case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointers, count and flags; flags come from the next count so they are registered.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == NW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers and empty flag guard every read.
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/pet_key_injector.sv
// PET keyboard-matrix driver: queues key events and replays them as timed
// presses on the active-low KEYCOL return lines.
module pet_key_injector
  import pet_kbd_pkg::*;
#(
  parameter int ROWS       = PET_ROWS,
  parameter int COLS       = PET_COLS,
  parameter int DEPTH      = 16,
  parameter int TICK_DIV   = 100000,
  parameter int HOLD_TICKS = 40,
  parameter int GAP_TICKS  = 40,
  parameter int SHIFT_ROW  = PET_SHIFT_ROW,
  parameter int SHIFT_COL  = PET_SHIFT_COL,
  localparam int RW = idx_width(ROWS),
  localparam int CW = idx_width(COLS)
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            KEY_VALID,
  output logic            KEY_READY,
  input  logic [RW-1:0]   KEY_ROW,
  input  logic [CW-1:0]   KEY_COL,
  input  logic            KEY_SHIFT,
  input  logic [ROWS-1:0] KEYROW,
  output logic [COLS-1:0] KEYCOL,
  output logic            BUSY,
  output logic            ERR
);

  localparam int EW   = 1 + RW + CW;
  localparam int NW   = $clog2(DEPTH + 1);
  localparam int PW   = idx_width(TICK_DIV);
  localparam int TMAX = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
  localparam int TW   = idx_width(TMAX + 1);

  typedef struct packed {
    logic          shift;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
  } key_event_t;

  key_event_t             in_ev;
  key_event_t             out_ev;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [NW-1:0]          fifo_count;
  logic                   ready_en;
  logic                   accept;
  logic                   in_range;
  logic                   push;
  logic                   pop;

  kbd_state_t             state;
  kbd_state_t             state_next;
  logic [PW-1:0]          presc;
  logic [PW-1:0]          presc_next;
  logic [TW-1:0]          ticks;
  logic [TW-1:0]          ticks_next;
  logic                   tick;
  logic [ROWS-1:0][COLS-1:0] pressed;
  logic [ROWS-1:0][COLS-1:0] pressed_next;
  logic [COLS-1:0]        col_hit;

  // Handshake: ready only once out of reset and while the queue has room.
  assign KEY_READY = ready_en & ~fifo_full;
  assign accept    = KEY_VALID & KEY_READY;
  assign in_range  = (32'(KEY_ROW) < ROWS) && (32'(KEY_COL) < COLS);
  assign push      = accept & in_range;
  assign in_ev     = '{shift: KEY_SHIFT, row: KEY_ROW, col: KEY_COL};

  pet_key_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .push    (push),
    .pop     (pop),
    .wr_data (in_ev),
    .rd_data (out_ev),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Ready enable and the one-cycle error pulse for rejected coordinates.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      ready_en <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      ERR      <= accept & ~in_range;
    end
  end

  assign tick = (presc == PW'(TICK_DIV - 1));

  // Next-state logic: pop and press, hold for HOLD_TICKS, release for GAP_TICKS.
  always_comb begin
    state_next   = state;
    presc_next   = presc;
    ticks_next   = ticks;
    pressed_next = pressed;
    pop          = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          pressed_next = '0;
          for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
              if ((32'(out_ev.row) == r && 32'(out_ev.col) == c) ||
                  (out_ev.shift && r == SHIFT_ROW && c == SHIFT_COL)) begin
                pressed_next[r][c] = 1'b1;
              end
            end
          end
          presc_next = '0;
          ticks_next = '0;
          state_next = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (tick) begin
          presc_next = '0;
          if (ticks == TW'(HOLD_TICKS - 1)) begin
            ticks_next   = '0;
            pressed_next = '0;
            state_next   = ST_GAP;
          end else begin
            ticks_next = ticks + 1'b1;
          end
        end else begin
          presc_next = presc + 1'b1;
        end
      end
      ST_GAP: begin
        if (tick) begin
          presc_next = '0;
          if (ticks == TW'(GAP_TICKS - 1)) begin
            ticks_next = '0;
            state_next = ST_IDLE;
          end else begin
            ticks_next = ticks + 1'b1;
          end
        end else begin
          presc_next = presc + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM, timing counters and pressed matrix registers.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state   <= ST_IDLE;
      presc   <= '0;
      ticks   <= '0;
      pressed <= '0;
    end else begin
      state   <= state_next;
      presc   <= presc_next;
      ticks   <= ticks_next;
      pressed <= pressed_next;
    end
  end

  // Column hits for every selected (low) row; several low rows OR together.
  always_comb begin
    col_hit = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (!KEYROW[r] && pressed[r][c]) col_hit[c] = 1'b1;
      end
    end
  end

  // Registered column return and busy flag.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      KEYCOL <= '1;
      BUSY   <= 1'b0;
    end else begin
      KEYCOL <= ~col_hit;
      BUSY   <= (state_next != ST_IDLE) || (fifo_count != '0) || push;
    end
  end

endmodule

// File: tb/tb_pet_key_injector.sv
// Self-checking bench for pet_key_injector: directed tables plus randomized
// traffic against a timeline-based reference model.
module tb_pet_key_injector;

  localparam int TD       = 4;
  localparam int HT       = 3;
  localparam int GT       = 2;
  localparam int DP       = 4;
  localparam int HOLD_CYC = HT * TD;
  localparam int GAP_CYC  = GT * TD;
  localparam int SH_ROW   = 8;
  localparam int SH_COL   = 0;

  typedef struct {
    int row;
    int col;
    bit shift;
  } ev_t;

  typedef struct {
    logic [9:0] kr;
    logic [7:0] col;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic       key_shift;
  logic [9:0] keyrow;
  logic [7:0] keycol;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: queued events, key being played, and edge count.
  ev_t        q[$];
  ev_t        cur;
  bit         cur_act  = 1'b0;
  int         cur_p    = 0;
  int         next_pop = 0;
  int         ecnt     = 0;
  bit         m_ready  = 1'b0;
  logic [7:0] e_col    = 8'hFF;
  bit         e_busy   = 1'b0;
  bit         e_err    = 1'b0;
  bit         last_acc = 1'b0;

  pet_key_injector #(
    .DEPTH      (DP),
    .TICK_DIV   (TD),
    .HOLD_TICKS (HT),
    .GAP_TICKS  (GT)
  ) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .KEY_VALID (key_valid),
    .KEY_READY (key_ready),
    .KEY_ROW   (key_row),
    .KEY_COL   (key_col),
    .KEY_SHIFT (key_shift),
    .KEYROW    (keyrow),
    .KEYCOL    (keycol),
    .BUSY      (busy),
    .ERR       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  // Active-low column return for one pressed key (plus SHIFT) under a row pattern.
  function automatic logic [7:0] model_col(input logic [9:0] kr, input bit act, input ev_t ev);
    logic [7:0] res;
    res = 8'hFF;
    if (act) begin
      if (!kr[ev.row]) res[ev.col] = 1'b0;
      if (ev.shift && !kr[SH_ROW]) res[SH_COL] = 1'b0;
    end
    return res;
  endfunction

  // One clock edge: advance the model with the pre-edge inputs, then compare.
  task automatic cyc();
    bit         acc;
    bit         inr;
    logic [9:0] kr_pre;
    ev_t        ev;
    acc    = rst_n && key_valid && m_ready;
    inr    = (int'(key_row) < 10);
    kr_pre = keyrow;
    ev     = '{row: int'(key_row), col: int'(key_col), shift: key_shift};
    @(posedge clk);
    #1;
    ecnt++;
    if (!rst_n) begin
      q.delete();
      cur_act  = 1'b0;
      next_pop = 0;
      m_ready  = 1'b0;
      e_col    = 8'hFF;
      e_busy   = 1'b0;
      e_err    = 1'b0;
      last_acc = 1'b0;
    end else begin
      e_col = model_col(kr_pre, cur_act && ecnt > cur_p && ecnt <= cur_p + HOLD_CYC, cur);
      if (q.size() > 0 && ecnt >= next_pop) begin
        cur      = q.pop_front();
        cur_act  = 1'b1;
        cur_p    = ecnt;
        next_pop = ecnt + 1 + HOLD_CYC + GAP_CYC;
      end
      if (acc && inr) q.push_back(ev);
      e_err    = acc && !inr;
      e_busy   = (q.size() > 0) || (cur_act && ecnt < cur_p + HOLD_CYC + GAP_CYC);
      m_ready  = (q.size() < DP);
      last_acc = acc;
    end
    check("keycol", keycol, e_col);
    check("key_ready", key_ready, m_ready);
    check("busy", busy, e_busy);
    check("err", err, e_err);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (e_busy && n < budget);
    if (e_busy) begin
      n_checks++;
      n_err++;
      $display("FAIL idle_timeout: still busy after %0d cycles", n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    ev_t  bp_ev[6];
    int   acc_cnt;
    int   n0;
    int   last_edge;
    int   guard;
    int   scan;

    // Reset with an event offered: nothing may be accepted.
    rst_n     = 1'b0;
    key_valid = 1'b1;
    key_row   = 4'd3;
    key_col   = 3'd5;
    key_shift = 1'b0;
    keyrow    = '1;
    repeat (5) cyc();
    check("rst_keycol", keycol, 8'hFF);
    check("rst_ready", key_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    key_valid = 1'b0;
    rst_n     = 1'b1;
    cyc();
    check("ready_after_rst", key_ready, 1'b1);

    // Single key row 3 col 5, row 3 scanned; one cycle of row 4 mid-press.
    keyrow    = ~(10'd1 << 3);
    key_valid = 1'b1;
    cyc();
    key_valid = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      keyrow = (k == 6) ? ~(10'd1 << 4) : ~(10'd1 << 3);
      cyc();
      check("single_col", keycol, (k >= 2 && k <= 13 && k != 6) ? 8'hDF : 8'hFF);
      if (k == 20) check("single_busy_hi", busy, 1'b1);
      if (k == 21) check("single_busy_lo", busy, 1'b0);
    end

    // SHIFT decode table for event row 2 col 1 with shift.
    tbl[0] = '{10'h3FB, 8'hFD, "shift_row2"};
    tbl[1] = '{10'h2FF, 8'hFE, "shift_row8"};
    tbl[2] = '{10'h2FB, 8'hFC, "shift_both"};
    tbl[3] = '{10'h3FF, 8'hFF, "shift_none"};
    tbl[4] = '{10'h3F7, 8'hFF, "shift_row3"};
    keyrow    = '1;
    key_row   = 4'd2;
    key_col   = 3'd1;
    key_shift = 1'b1;
    key_valid = 1'b1;
    cyc();
    key_valid = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      keyrow = tbl[i].kr;
      cyc();
      check(tbl[i].name, keycol, tbl[i].col);
    end
    keyrow = '1;
    wait_idle(100);

    // Back-pressure: six events, all rows selected so every press and gap is seen.
    bp_ev[0] = '{3, 5, 1'b0};
    bp_ev[1] = '{3, 5, 1'b0};
    bp_ev[2] = '{8, 0, 1'b1};
    bp_ev[3] = '{0, 7, 1'b1};
    bp_ev[4] = '{9, 2, 1'b0};
    bp_ev[5] = '{5, 4, 1'b0};
    keyrow    = '0;
    acc_cnt   = 0;
    last_edge = 0;
    guard     = 0;
    n0        = ecnt + 1;
    while (acc_cnt < 6 && guard < 200) begin
      key_row   = 4'(bp_ev[acc_cnt].row);
      key_col   = 3'(bp_ev[acc_cnt].col);
      key_shift = bp_ev[acc_cnt].shift;
      key_valid = 1'b1;
      cyc();
      if (last_acc) begin
        acc_cnt++;
        last_edge = ecnt;
        if (acc_cnt == 5) check("bp_ready_low_full", key_ready, 1'b0);
      end
      guard++;
    end
    key_valid = 1'b0;
    check("bp_all_accepted", acc_cnt, 6);
    check("bp_sixth_edge", last_edge - n0, 23);
    wait_idle(400);

    // Out-of-range row: accepted, one ERR pulse, nothing queued.
    key_row   = 4'd12;
    key_col   = 3'd0;
    key_shift = 1'b0;
    key_valid = 1'b1;
    cyc();
    key_valid = 1'b0;
    check("err_pulse", err, 1'b1);
    cyc();
    check("err_one_cycle", err, 1'b0);
    check("err_busy", busy, 1'b0);
    cyc();
    check("err_keycol", keycol, 8'hFF);

    // Reset during a press with two events still queued.
    key_shift = 1'b0;
    key_valid = 1'b1;
    key_row = 4'd1; key_col = 3'd1; cyc();
    key_row = 4'd2; key_col = 3'd2; cyc();
    key_row = 4'd4; key_col = 3'd6; cyc();
    key_valid = 1'b0;
    repeat (3) cyc();
    check("midrst_pressed", keycol, 8'hFD);
    rst_n = 1'b0;
    cyc();
    check("midrst_keycol", keycol, 8'hFF);
    check("midrst_busy", busy, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 60; k++) begin
      cyc();
      check("midrst_no_replay", keycol, 8'hFF);
    end

    // Randomized traffic with a rotating scan and occasional resets.
    scan = 0;
    for (int k = 0; k < 700; k++) begin
      int mode;
      rst_n     = ($urandom_range(0, 249) != 0);
      key_valid = ($urandom_range(0, 3) == 0);
      key_row   = 4'($urandom_range(0, 11));
      key_col   = 3'($urandom_range(0, 7));
      key_shift = 1'($urandom_range(0, 1));
      mode      = $urandom_range(0, 9);
      if (mode == 0)      keyrow = '1;
      else if (mode == 1) keyrow = ~((10'd1 << $urandom_range(0, 9)) | (10'd1 << $urandom_range(0, 9)));
      else                keyrow = ~(10'd1 << scan);
      scan = (scan + 1) % 10;
      cyc();
    end
    rst_n     = 1'b1;
    key_valid = 1'b0;
    keyrow    = '0;
    wait_idle(200);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
